// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline hazard/stall controller.
//   ctrl_state_t : controller FSM states
//   REG_ADDR_W   : register-number width
//   CNT_W        : statistics counter width
//   sat_inc      : saturating increment for the statistics counters
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MULTI_WAIT = 2'd1,
    HALT       = 2'd2
  } ctrl_state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// load_use_detect
// Pure comparator: flags a load in EXE whose destination is read by the
// instruction currently in ID.
//   id_rs1/id_rs2          in  source register numbers in ID
//   id_rs1_used/_rs2_used  in  ID instruction really reads that source
//   exe_rd                 in  destination register of the EXE instruction
//   exe_mem_read           in  EXE instruction is a load
//   load_use               out hazard present this cycle
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_mem_read,
  output logic                  load_use
);

  // R0 is compared like any other register; no zero-register exemption.
  assign load_use = exe_mem_read &&
                    ((id_rs1_used && (id_rs1 == exe_rd)) ||
                     (id_rs2_used && (id_rs2 == exe_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Hazard and stall controller for the five-stage pipeline. Drives the
// load enables / bubble flushes of the PC, IF/ID, ID/EXE and EXE/MEM
// registers, handles load-use, taken branch, multi-cycle EXE ops and HALT,
// freezes everything while data memory is busy, and keeps statistics.
//   clk, reset                    clock, synchronous active-high reset
//   id_rs1/2, id_rs1/2_used       ID-stage source operands
//   exe_rd, exe_mem_read          EXE-stage destination / load flag
//   exe_branch_taken, exe_halt    EXE-stage control events
//   exe_multi_start, multi_done   multi-cycle op handshake
//   mem_busy                      data memory not ready
//   resume                        leave HALT
//   pc_en .. exe_mem_en           register load enables
//   if_id_flush .. exe_mem_flush  load a NOP bubble
//   halted                        state is HALT
//   mem_timeout_err               sticky memory-timeout flag
//   stall_cnt, flush_cnt          saturating statistics
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_mem_read,
  input  logic                  exe_branch_taken,
  input  logic                  exe_halt,
  input  logic                  exe_multi_start,
  input  logic                  multi_done,
  input  logic                  mem_busy,
  input  logic                  resume,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_exe_en,
  output logic                  exe_mem_en,
  output logic                  if_id_flush,
  output logic                  id_exe_flush,
  output logic                  exe_mem_flush,
  output logic                  halted,
  output logic                  mem_timeout_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int BUSY_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(MEM_TIMEOUT);

  ctrl_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;
  logic [BUSY_W-1:0] busy_cnt_reg, busy_cnt_next;
  logic              timeout_reg;
  logic              stall_inc, flush_inc;
  logic              load_use;

  load_use_detect u_load_use_detect (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .exe_rd       (exe_rd),
    .exe_mem_read (exe_mem_read),
    .load_use     (load_use)
  );

  // Next state, Mealy outputs and counter strobes.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_exe_en     = 1'b1;
    exe_mem_en    = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    state_next    = state_reg;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    if (reset || mem_busy) begin
      // Full freeze: nothing loads and nothing is bubbled; state holds.
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_exe_en  = 1'b0;
      exe_mem_en = 1'b0;
      stall_inc  = !reset;
    end else begin
      case (state_reg)
        RUN: begin
          if (exe_branch_taken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
            flush_inc    = 1'b1;
          end else if (exe_halt) begin
            // HALT moves on to MEM; younger instructions are held.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
            stall_inc    = 1'b1;
            state_next   = HALT;
          end else if (exe_multi_start) begin
            // Multi-cycle op stays in EXE; MEM gets bubbles meanwhile.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_flush = 1'b1;
            stall_inc     = 1'b1;
            state_next    = MULTI_WAIT;
          end else if (load_use) begin
            // One bubble: the load reaches MEM on this edge.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
            stall_inc    = 1'b1;
          end
        end
        MULTI_WAIT: begin
          if (multi_done) begin
            state_next = RUN;
          end else begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_flush = 1'b1;
            stall_inc     = 1'b1;
          end
        end
        HALT: begin
          // Front end frozen, back end drains; not counted as a stall.
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_exe_flush = 1'b1;
          if (resume) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // Consecutive-busy counter, saturating at the timeout threshold.
  always_comb begin
    busy_cnt_next = '0;
    if (mem_busy) begin
      busy_cnt_next = (busy_cnt_reg == BUSY_MAX) ? busy_cnt_reg : busy_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
      busy_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      busy_cnt_reg <= busy_cnt_next;
      if (stall_inc) begin
        stall_cnt_reg <= sat_inc(stall_cnt_reg);
      end
      if (flush_inc) begin
        flush_cnt_reg <= sat_inc(flush_cnt_reg);
      end
      // The error registers on the same edge the busy run hits the threshold.
      if (busy_cnt_next == BUSY_MAX) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign halted          = (state_reg == HALT) && !reset;
  assign mem_timeout_err = timeout_reg;
  assign stall_cnt       = stall_cnt_reg;
  assign flush_cnt       = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rs1, id_rs2, exe_rd;
  logic       id_rs1_used, id_rs2_used, exe_mem_read;
  logic       exe_branch_taken, exe_halt, exe_multi_start, multi_done;
  logic       mem_busy, resume;
  logic       pc_en, if_id_en, id_exe_en, exe_mem_en;
  logic       if_id_flush, id_exe_flush, exe_mem_flush;
  logic       halted, mem_timeout_err;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: "where is the pipeline" as two flags plus plain counts.
  bit m_in_multi, m_in_halt, m_err;
  int m_stall, m_flush, m_busy_run;

  pipeline_ctrl #(.MEM_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .exe_rd(exe_rd), .exe_mem_read(exe_mem_read),
    .exe_branch_taken(exe_branch_taken), .exe_halt(exe_halt),
    .exe_multi_start(exe_multi_start), .multi_done(multi_done),
    .mem_busy(mem_busy), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en), .exe_mem_en(exe_mem_en),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush), .exe_mem_flush(exe_mem_flush),
    .halted(halted), .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard();
    return exe_mem_read && ((id_rs1_used && id_rs1 == exe_rd) || (id_rs2_used && id_rs2 == exe_rd));
  endfunction

  // Expected {pc_en,if_id_en,id_exe_en,exe_mem_en,if_id_flush,id_exe_flush,exe_mem_flush}
  function automatic logic [6:0] exp_ctrl();
    localparam logic [6:0] NORMAL = 7'b1111_000;
    localparam logic [6:0] FROZEN = 7'b0000_000;
    localparam logic [6:0] BRANCH = 7'b1111_110;
    localparam logic [6:0] HOLD_FRONT = 7'b0011_010; // halt / load-use / halted drain
    localparam logic [6:0] MULTI = 7'b0001_001;
    if (reset || mem_busy) return FROZEN;
    if (m_in_multi) return multi_done ? NORMAL : MULTI;
    if (m_in_halt) return HOLD_FRONT;
    if (exe_branch_taken) return BRANCH;
    if (exe_halt) return HOLD_FRONT;
    if (exe_multi_start) return MULTI;
    if (hazard()) return HOLD_FRONT;
    return NORMAL;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    if (reset) begin
      m_in_multi = 0; m_in_halt = 0; m_err = 0;
      m_stall = 0; m_flush = 0; m_busy_run = 0;
    end else if (mem_busy) begin
      m_stall = sat16(m_stall + 1);
      m_busy_run = (m_busy_run >= 255) ? 255 : m_busy_run + 1;
      if (m_busy_run == 255) m_err = 1;
    end else begin
      m_busy_run = 0;
      if (m_in_multi) begin
        if (multi_done) m_in_multi = 0; else m_stall = sat16(m_stall + 1);
      end else if (m_in_halt) begin
        if (resume) m_in_halt = 0;
      end else if (exe_branch_taken) begin
        m_flush = sat16(m_flush + 1);
      end else if (exe_halt) begin
        m_stall = sat16(m_stall + 1); m_in_halt = 1;
      end else if (exe_multi_start) begin
        m_stall = sat16(m_stall + 1); m_in_multi = 1;
      end else if (hazard()) begin
        m_stall = sat16(m_stall + 1);
      end
    end
  endtask

  // One clock: check Mealy outputs mid-cycle, then registered state after the edge.
  task automatic tick();
    #2;
    chk("ctrl", {25'd0, pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_flush, exe_mem_flush},
        {25'd0, exp_ctrl()});
    chk("halted_comb", {31'd0, halted}, {31'd0, (!reset && m_in_halt)});
    @(posedge clk);
    model_edge();
    #1;
    chk("state", {halted, mem_timeout_err, stall_cnt, flush_cnt},
        {16'd0, m_in_halt, m_err, m_stall[15:0], m_flush[15:0]});
  endtask

  task automatic idle();
    reset = 0; id_rs1 = 0; id_rs2 = 0; exe_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; exe_mem_read = 0;
    exe_branch_taken = 0; exe_halt = 0; exe_multi_start = 0;
    multi_done = 0; mem_busy = 0; resume = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
    chk("reset_flush", {16'd0, flush_cnt}, 32'd0);
    reset = 0;
    tick();

    // Load-use on rs2, then the same without rs2 used.
    exe_mem_read = 1; exe_rd = 4'd3; id_rs2 = 4'd3; id_rs2_used = 1; id_rs1 = 4'd7;
    tick();
    chk("lu_stall", {16'd0, stall_cnt}, 32'd1);
    id_rs2_used = 0;
    tick();
    chk("lu_unused", {16'd0, stall_cnt}, 32'd1);
    // R0 hazard is not exempt.
    exe_rd = 4'd0; id_rs1 = 4'd0; id_rs1_used = 1;
    tick();
    chk("lu_r0", {16'd0, stall_cnt}, 32'd2);

    // Branch beats load-use.
    do_reset();
    exe_mem_read = 1; exe_rd = 4'd3; id_rs2 = 4'd3; id_rs2_used = 1; exe_branch_taken = 1;
    tick();
    chk("prio_flush", {16'd0, flush_cnt}, 32'd1);
    chk("prio_stall", {16'd0, stall_cnt}, 32'd0);

    // Multi-cycle op, done after 3 waiting cycles.
    do_reset();
    exe_multi_start = 1;
    tick();
    exe_multi_start = 0;
    repeat (3) tick();
    multi_done = 1;
    tick();
    multi_done = 0;
    tick();
    chk("multi_stall", {16'd0, stall_cnt}, 32'd4);
    // Done already high in the start cycle: exactly one wait cycle.
    exe_multi_start = 1; multi_done = 1;
    tick();
    exe_multi_start = 0;
    tick();
    chk("multi_min", {16'd0, stall_cnt}, 32'd5);

    // HALT and resume.
    do_reset();
    exe_halt = 1;
    tick();
    exe_halt = 0;
    chk("halt_enter", {31'd0, halted}, 32'd1);
    repeat (5) tick();
    resume = 1;
    tick();
    resume = 0;
    chk("halt_exit", {31'd0, halted}, 32'd0);
    chk("halt_stall", {16'd0, stall_cnt}, 32'd1);

    // Memory busy in MULTI_WAIT with multi_done high: timeout after 255 edges.
    do_reset();
    exe_multi_start = 1;
    tick();
    exe_multi_start = 0; multi_done = 1; mem_busy = 1;
    repeat (254) tick();
    chk("timeout_254", {31'd0, mem_timeout_err}, 32'd0);
    tick();
    chk("timeout_255", {31'd0, mem_timeout_err}, 32'd1);
    repeat (3) tick();
    mem_busy = 0;
    tick();
    multi_done = 0;
    tick();
    chk("timeout_sticky", {31'd0, mem_timeout_err}, 32'd1);

    // Reset in HALT clears everything.
    exe_halt = 1;
    tick();
    exe_halt = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_halt", {halted, mem_timeout_err, stall_cnt}, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 99) == 0);
      id_rs1           = 4'($urandom_range(0, 3));
      id_rs2           = 4'($urandom_range(0, 3));
      exe_rd           = 4'($urandom_range(0, 3));
      id_rs1_used      = 1'($urandom_range(0, 1));
      id_rs2_used      = 1'($urandom_range(0, 1));
      exe_mem_read     = ($urandom_range(0, 2) == 0);
      exe_branch_taken = ($urandom_range(0, 7) == 0);
      exe_halt         = ($urandom_range(0, 15) == 0);
      exe_multi_start  = ($urandom_range(0, 9) == 0);
      multi_done       = ($urandom_range(0, 2) == 0);
      mem_busy         = ($urandom_range(0, 9) == 0);
      resume           = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Saturation: a persistent load-use hazard for 70000 cycles.
    do_reset();
    exe_mem_read = 1; exe_rd = 4'd5; id_rs1 = 4'd5; id_rs1_used = 1;
    repeat (70000) tick();
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
